// File: rtl/mdu_ctrl.sv
// mdu_ctrl: RISC-V M-extension issue/retire controller for the EX stage.
//
// Sits directly upstream of the MCycle multi-cycle multiply/divide unit. It
// decodes Funct3 and maps each op onto MCycle's four ops, then drives the
// MC_Start handshake. It stalls the pipeline until MCycle drops MC_Busy, and
// then selects and sign-fixes the 32-bit writeback value. Divide-by-zero and
// signed overflow are resolved locally in one cycle and never reach MCycle.
//
// Ports:
//   CLK, RESETN      clock, asynchronous active-low reset
//   MDUValid         M-ext instruction present in EX (held stable while stalled)
//   Funct3           000 MUL .. 111 REMU
//   RS1, RS2         source operands
//   MDUResult        writeback value (0 unless MDUDone)
//   MDUDone          one-cycle result-valid pulse
//   MDUStall         freeze IF/ID/EX
//   MC_Start/MC_Op/MC_Operand1/MC_Operand2   request to MCycle
//   MC_Result1/MC_Result2/MC_Busy            response from MCycle
//
// Optional feature (macro MDU_RESULT_CACHE_EN): a single-entry cache of the
// last MCycle result. It lets a matching follow-up op (e.g. REM after DIV)
// complete in one cycle without issuing to MCycle.
//
// Outputs in the Start cycle and in the single-cycle completion paths must
// reflect the current inputs. For that reason they are decoded combinationally
// from the state registers and the inputs. All stored state is registered.

module mdu_ctrl #(
  parameter int width = 32
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               MDUValid,
  input  logic [2:0]         Funct3,
  input  logic [width-1:0]   RS1,
  input  logic [width-1:0]   RS2,
  output logic [width-1:0]   MDUResult,
  output logic               MDUDone,
  output logic               MDUStall,
  output logic               MC_Start,
  output logic [1:0]         MC_Op,
  output logic [width-1:0]   MC_Operand1,
  output logic [width-1:0]   MC_Operand2,
  input  logic [width-1:0]   MC_Result1,
  input  logic [width-1:0]   MC_Result2,
  input  logic               MC_Busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t               r_state;
  logic [2:0]           r_f3;
  logic                 r_neg;
  logic                 r_flush;
  logic [2*width-1:0]   r_p;

  // Low word for MUL, DIV and DIVU. High word for MULH*, REM and REMU.
  function automatic logic [width-1:0] sel_result(input logic [2:0] f3,
                                                  input logic [2*width-1:0] p);
    logic is_lo;
    is_lo = (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b101);
    return is_lo ? p[width-1:0] : p[2*width-1:width];
  endfunction

  logic [1:0]           w_mc_op;
  logic                 w_neg;
  logic [width-1:0]     w_op1;
  logic                 w_div0;
  logic                 w_ovf;
  logic                 w_special;
  logic [width-1:0]     w_spec_res;
  logic [2*width-1:0]   w_cap;
  logic [2*width-1:0]   w_p_new;
  logic                 w_hit;
  logic [width-1:0]     w_hit_res;

  // Funct3 decode: the MCycle op, plus MULHSU's magnitude/sign split of RS1.
  always_comb begin
    case (Funct3)
      3'b000, 3'b001: w_mc_op = 2'b00;
      3'b010, 3'b011: w_mc_op = 2'b01;
      3'b100, 3'b110: w_mc_op = 2'b10;
      3'b101, 3'b111: w_mc_op = 2'b11;
      default:        w_mc_op = 2'b00;
    endcase
    // MCycle only has an unsigned x unsigned multiply for op 01. So MULHSU
    // multiplies |RS1| and negates the 64-bit product afterwards.
    w_neg = (Funct3 == 3'b010) && RS1[width-1];
    if (w_neg) begin
      w_op1 = ~RS1 + 32'd1;
    end else begin
      w_op1 = RS1;
    end
  end

  // Locally resolved divide cases: divide-by-zero and signed overflow.
  always_comb begin
    w_div0 = Funct3[2] && (RS2 == 32'd0);
    w_ovf  = ((Funct3 == 3'b100) || (Funct3 == 3'b110)) &&
             (RS1 == 32'h8000_0000) && (RS2 == 32'hFFFF_FFFF);
    w_special = w_div0 || w_ovf;
    if (w_div0) begin
      w_spec_res = Funct3[1] ? RS1 : 32'hFFFF_FFFF;
    end else if (w_ovf) begin
      w_spec_res = Funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end else begin
      w_spec_res = 32'h0000_0000;
    end
  end

  // MCycle response, negated when the MULHSU sign flag was set at issue.
  always_comb begin
    w_cap = {MC_Result2, MC_Result1};
    if (r_neg) begin
      w_p_new = ~w_cap + 64'd1;
    end else begin
      w_p_new = w_cap;
    end
  end

`ifdef MDU_RESULT_CACHE_EN
  logic [width-1:0]     r_rs1;
  logic [width-1:0]     r_rs2;
  logic [1:0]           r_op;
  logic                 r_c_vld;
  logic [width-1:0]     r_c_rs1;
  logic [width-1:0]     r_c_rs2;
  logic [1:0]           r_c_op;
  logic                 r_c_neg;
  logic [2*width-1:0]   r_c_p;

  // Cache lookup. MUL needs only the low product word, which is the same for
  // every multiply class. Every other op needs the same MCycle op and the same
  // sign fix-up. This keeps MULHSU with negative RS1 apart from MULHU.
  always_comb begin
    if (r_c_vld && (r_c_rs1 == RS1) && (r_c_rs2 == RS2)) begin
      if (Funct3 == 3'b000) begin
        w_hit = !r_c_op[1];
      end else begin
        w_hit = (r_c_op == w_mc_op) && (r_c_neg == w_neg);
      end
    end else begin
      w_hit = 1'b0;
    end
    w_hit_res = sel_result(Funct3, r_c_p);
  end
`else
  // No cache: every non-special op issues to MCycle.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_res = 32'h0000_0000;
  end
`endif

  // Control FSM and capture registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= S_IDLE;
      r_f3    <= 3'b000;
      r_neg   <= 1'b0;
      r_flush <= 1'b0;
      r_p     <= 64'd0;
`ifdef MDU_RESULT_CACHE_EN
      r_rs1   <= 32'd0;
      r_rs2   <= 32'd0;
      r_op    <= 2'b00;
      r_c_vld <= 1'b0;
      r_c_rs1 <= 32'd0;
      r_c_rs2 <= 32'd0;
      r_c_op  <= 2'b00;
      r_c_neg <= 1'b0;
      r_c_p   <= 64'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MDUValid && !w_special && !w_hit) begin
            r_f3    <= Funct3;
            r_neg   <= w_neg;
            r_flush <= 1'b0;
`ifdef MDU_RESULT_CACHE_EN
            r_rs1   <= RS1;
            r_rs2   <= RS2;
            r_op    <= w_mc_op;
`endif
            r_state <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          // A flushed op still has to drain MCycle. Its result is only suppressed.
          if (!MDUValid) begin
            r_flush <= 1'b1;
          end else begin
            r_flush <= r_flush;
          end
          if (!MC_Busy) begin
            r_p     <= w_p_new;
`ifdef MDU_RESULT_CACHE_EN
            r_c_vld <= 1'b1;
            r_c_rs1 <= r_rs1;
            r_c_rs2 <= r_rs2;
            r_c_op  <= r_op;
            r_c_neg <= r_neg;
            r_c_p   <= w_p_new;
`endif
            r_state <= S_DONE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode. RESETN gates everything so outputs are 0 throughout reset.
  always_comb begin
    MDUResult   = 32'h0000_0000;
    MDUDone     = 1'b0;
    MDUStall    = 1'b0;
    MC_Start    = 1'b0;
    MC_Op       = 2'b00;
    MC_Operand1 = 32'h0000_0000;
    MC_Operand2 = 32'h0000_0000;
    if (RESETN) begin
      case (r_state)
        S_IDLE: begin
          if (MDUValid) begin
            if (w_special) begin
              MDUDone   = 1'b1;
              MDUResult = w_spec_res;
            end else if (w_hit) begin
              MDUDone   = 1'b1;
              MDUResult = w_hit_res;
            end else begin
              MC_Start    = 1'b1;
              MDUStall    = 1'b1;
              MC_Op       = w_mc_op;
              MC_Operand1 = w_op1;
              MC_Operand2 = RS2;
            end
          end else begin
            MDUDone = 1'b0;
          end
        end
        S_WAIT: begin
          MDUStall = 1'b1;
        end
        S_DONE: begin
          if (!r_flush) begin
            MDUDone   = 1'b1;
            MDUResult = sel_result(r_f3, r_p);
          end else begin
            MDUDone = 1'b0;
          end
        end
        default: begin
          MDUStall = 1'b0;
        end
      endcase
    end else begin
      MDUStall = 1'b0;
    end
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- RISC-V M-extension issue/retire controller in the EX stage, directly upstream of the MCycle multi-cycle multiply/divide unit.
- Decodes funct3, maps each op onto MCycle's four ops and drives its Start handshake.
- Stalls the pipeline until MCycle finishes, then selects and sign-fixes the 32-bit writeback value.
- Resolves divide-by-zero and signed overflow locally, in a single cycle, without issuing to MCycle.

Parameters:
- width, 32, operand/result width; only 32 is supported.

Ports:
- CLK  in  1  clock
- RESETN  in  1  asynchronous active-low reset
- MDUValid  in  1  M-ext instruction present in EX; held stable by the pipeline while MDUStall=1
- Funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- RS1  in  width  source operand 1
- RS2  in  width  source operand 2
- MDUResult  out  width  writeback value, valid only when MDUDone=1, else 0
- MDUDone  out  1  one-cycle pulse, result valid
- MDUStall  out  1  freeze IF/ID/EX
- MC_Start  out  1  MCycle Start
- MC_Op  out  2  MCycle op
- MC_Operand1  out  width  MCycle Operand1
- MC_Operand2  out  width  MCycle Operand2
- MC_Result1  in  width  MCycle LSW/quotient
- MC_Result2  in  width  MCycle MSW/remainder
- MC_Busy  in  1  MCycle Busy

Behaviour:
- Reset (RESETN=0, async): state IDLE; capture registers, neg flag and cache valid cleared; all outputs 0.
- Op mapping:
  - MUL/MULH -> MC_Op=00.
  - MULHSU -> MC_Op=01, MC_Operand1=|RS1| (two's complement), neg flag = RS1[31].
  - MULHU -> 01.
  - DIV/REM -> 10.
  - DIVU/REMU -> 11.
  - Otherwise MC_Operand1=RS1, MC_Operand2=RS2.
  - Operands and MC_Op are combinational from the inputs and valid in the Start cycle.
- Special cases (IDLE, MDUValid=1), all completing the same cycle with MDUDone=1, MDUStall=0, MC_Start=0:
  - RS2=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> RS1.
  - DIV with RS1=0x80000000, RS2=0xFFFFFFFF -> 0x80000000; REM -> 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - MDUValid=1, not special -> MC_Start=1, MDUStall=1; latch Funct3 and neg flag; next state WAIT.
  - MDUValid=0 -> all outputs 0.
- WAIT:
  - MDUStall=1, MC_Start=0.
  - When MC_Busy=0: capture {MC_Result2, MC_Result1} into 64-bit register P; if neg flag, P <= two's complement of the 64-bit value; next state DONE.
- DONE:
  - MDUStall=0, MDUDone=1.
  - MDUResult selected from P by latched Funct3: MUL=P[31:0], MULH/MULHSU/MULHU=P[63:32], DIV/DIVU=P[31:0], REM/REMU=P[63:32].
  - Next state IDLE unconditionally; a new op can issue the following cycle.
- Latency: 1 cycle for special cases; otherwise MCycle latency + 2 cycles (Start cycle excluded).
- MDUValid deasserting in WAIT (flush): still wait for MC_Busy=0; DONE then produces MDUDone=0 and MDUResult=0; next state IDLE.
- RESETN asserted mid-operation: immediate return to IDLE with all outputs 0. MCycle must be reset in the same reset event.
- MC_Start is never asserted outside IDLE.

Optional Feature:
- Macro MDU_RESULT_CACHE_EN.
- Enabled:
  - On each WAIT->DONE transition, store RS1, RS2, MC_Op, neg flag and P; set cache valid.
  - In IDLE with matching RS1/RS2, an op hits the cache and completes in one cycle from the stored P (MDUDone=1, no stall, no Start):
    - MUL hits any stored multiply class;
    - MULH/MULHSU/MULHU hit only the identical class;
    - DIV<->REM hit each other; DIVU<->REMU hit each other.
  - Special cases do not update the cache. Reset invalidates it.
- Disabled: no cache registers; every non-special op issues to MCycle.

Test Plan:
- MUL RS1=7, RS2=0xFFFFFFFD -> one MC_Start pulse with MC_Op=00; MDUStall high until DONE; MDUResult=0xFFFFFFEB with MDUDone one cycle.
- MULHSU RS1=0xFFFFFFFF, RS2=0xFFFFFFFF -> MC_Op=01, MC_Operand1=1; MDUResult=0xFFFFFFFF.
- DIV RS1=0xFFFFFFF9 (-7), RS2=2 -> 0xFFFFFFFD; then REM with same operands -> 0xFFFFFFFF. With MDU_RESULT_CACHE_EN, the REM completes in 1 cycle with no MC_Start.
- DIVU RS1=0x1234, RS2=0 -> same cycle MDUResult=0xFFFFFFFF, MDUStall=0, MC_Start=0; REM RS1=0x80000000, RS2=0xFFFFFFFF -> 0.
- RESETN pulsed low while in WAIT -> outputs 0 immediately; after release a MULHU 0xFFFFFFFF*0xFFFFFFFF returns 0xFFFFFFFE.
- MDUValid dropped during WAIT -> no MDUDone pulse; IDLE after MC_Busy falls; a back-to-back op issues the next cycle.
